// File: rtl/rename_unit_mw.sv
// -----------------------------------------------------------------------------
// rename_unit_mw
//   Multi-wide register rename stage. Up to RENAME_WIDTH instructions per cycle
//   (slot 0 oldest) read their source mappings from the speculative map. Each
//   instruction that writes a nonzero destination takes a fresh physical
//   register from a circular free list. Retirements update the committed map
//   and return the superseded register to the free list. A flush rolls the
//   speculative state back to the committed state.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ren_valid, ren_wen             per-slot instruction present / writes rd
//   ren_rs, ren_rt, ren_rd         per-slot architectural indices (packed)
//   ren_ready                      group accepted this cycle (combinational)
//   ren_prs, ren_prt               per-slot physical sources (combinational)
//   ren_prd, ren_old_prd           per-slot new dest / previous rd mapping
//   commit_valid, commit_ard,
//   commit_prd, commit_old_prd     one in-order retirement per cycle
//   flush                          discard all uncommitted renames
//   free_count                     registered count of allocatable registers
// -----------------------------------------------------------------------------
module rename_unit_mw #(
  parameter int ARCH_REG_WIDTH = 5,
  parameter int PHYS_REG_WIDTH = 6,
  parameter int RENAME_WIDTH   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [RENAME_WIDTH-1:0]                ren_valid,
  input  logic [RENAME_WIDTH-1:0]                ren_wen,
  input  logic [RENAME_WIDTH*ARCH_REG_WIDTH-1:0] ren_rs,
  input  logic [RENAME_WIDTH*ARCH_REG_WIDTH-1:0] ren_rt,
  input  logic [RENAME_WIDTH*ARCH_REG_WIDTH-1:0] ren_rd,
  output logic                                   ren_ready,
  output logic [RENAME_WIDTH*PHYS_REG_WIDTH-1:0] ren_prs,
  output logic [RENAME_WIDTH*PHYS_REG_WIDTH-1:0] ren_prt,
  output logic [RENAME_WIDTH*PHYS_REG_WIDTH-1:0] ren_prd,
  output logic [RENAME_WIDTH*PHYS_REG_WIDTH-1:0] ren_old_prd,
  input  logic                                   commit_valid,
  input  logic [ARCH_REG_WIDTH-1:0]              commit_ard,
  input  logic [PHYS_REG_WIDTH-1:0]              commit_prd,
  input  logic [PHYS_REG_WIDTH-1:0]              commit_old_prd,
  input  logic                                   flush,
  output logic [PHYS_REG_WIDTH:0]                free_count
);

  localparam int ARCH_REGS = 1 << ARCH_REG_WIDTH;
  localparam int PHYS_REGS = 1 << PHYS_REG_WIDTH;
  localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;
  localparam int IDX_W     = $clog2(FL_DEPTH);
  localparam int PTR_W     = IDX_W + 1;             // index plus wrap bit
  localparam int CNT_W     = $clog2(RENAME_WIDTH + 1);

  // Advance a free-list pointer by n entries. The index wraps modulo FL_DEPTH
  // (which need not be a power of two) and the wrap bit toggles on each pass.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    logic [IDX_W:0] s;
    logic           wrap;
    s    = {1'b0, p[IDX_W-1:0]} + (IDX_W+1)'(n);
    wrap = p[IDX_W];
    if (s >= (IDX_W+1)'(FL_DEPTH)) begin
      s    = s - (IDX_W+1)'(FL_DEPTH);
      wrap = ~wrap;
    end
    return {wrap, s[IDX_W-1:0]};
  endfunction

  // Storage index of the entry n places past pointer p.
  function automatic logic [IDX_W-1:0] fl_idx(input logic [PTR_W-1:0] p,
                                              input logic [CNT_W-1:0] n);
    logic [PTR_W-1:0] q;
    q = ptr_add(p, n);
    return q[IDX_W-1:0];
  endfunction

  // Occupancy between two pointers; differing wrap bits mean tail has lapped.
  function automatic logic [PHYS_REG_WIDTH:0] ptr_diff(input logic [PTR_W-1:0] t,
                                                      input logic [PTR_W-1:0] h);
    logic [PHYS_REG_WIDTH:0] tv;
    logic [PHYS_REG_WIDTH:0] hv;
    tv = (PHYS_REG_WIDTH+1)'(t[IDX_W-1:0]);
    hv = (PHYS_REG_WIDTH+1)'(h[IDX_W-1:0]);
    if (t[IDX_W] != h[IDX_W]) tv = tv + (PHYS_REG_WIDTH+1)'(FL_DEPTH);
    return tv - hv;
  endfunction

  logic [PHYS_REG_WIDTH-1:0] r_spec_map   [ARCH_REGS];
  logic [PHYS_REG_WIDTH-1:0] r_commit_map [ARCH_REGS];
  logic [PHYS_REG_WIDTH-1:0] r_free_list  [FL_DEPTH];
  logic [PTR_W-1:0]          r_head;
  logic [PTR_W-1:0]          r_commit_head;
  logic [PTR_W-1:0]          r_tail;
  logic [PHYS_REG_WIDTH:0]   r_free_count;

  logic [ARCH_REG_WIDTH-1:0] w_rs   [RENAME_WIDTH];
  logic [ARCH_REG_WIDTH-1:0] w_rt   [RENAME_WIDTH];
  logic [ARCH_REG_WIDTH-1:0] w_rd   [RENAME_WIDTH];
  logic [PHYS_REG_WIDTH-1:0] w_prs  [RENAME_WIDTH];
  logic [PHYS_REG_WIDTH-1:0] w_prt  [RENAME_WIDTH];
  logic [PHYS_REG_WIDTH-1:0] w_prd  [RENAME_WIDTH];
  logic [PHYS_REG_WIDTH-1:0] w_old  [RENAME_WIDTH];
  logic [RENAME_WIDTH-1:0]   w_alloc;
  logic [CNT_W-1:0]          w_alloc_cnt;
  logic                      w_accept;
  logic [PTR_W-1:0]          w_head_nxt;
  logic [PTR_W-1:0]          w_chead_nxt;
  logic [PTR_W-1:0]          w_tail_nxt;

  // Per-slot rename. Slots are walked oldest first so each slot sees the
  // allocations of all older slots in the group: its free-list offset is the
  // running allocation count, and any older allocating slot with a matching
  // rd overrides the speculative-map lookup (youngest match wins).
  always_comb begin
    w_alloc_cnt = '0;
    w_alloc     = '0;
    ren_prs     = '0;
    ren_prt     = '0;
    ren_prd     = '0;
    ren_old_prd = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      w_rs[k]    = ren_rs[k*ARCH_REG_WIDTH +: ARCH_REG_WIDTH];
      w_rt[k]    = ren_rt[k*ARCH_REG_WIDTH +: ARCH_REG_WIDTH];
      w_rd[k]    = ren_rd[k*ARCH_REG_WIDTH +: ARCH_REG_WIDTH];
      w_alloc[k] = ren_valid[k] & ren_wen[k] & (w_rd[k] != '0);

      w_prd[k] = w_alloc[k] ? r_free_list[fl_idx(r_head, w_alloc_cnt)] : '0;
      w_prs[k] = (w_rs[k] == '0) ? '0 : r_spec_map[w_rs[k]];
      w_prt[k] = (w_rt[k] == '0) ? '0 : r_spec_map[w_rt[k]];
      w_old[k] = r_spec_map[w_rd[k]];
      for (int j = 0; j < k; j++) begin
        if (w_alloc[j] && (w_rd[j] == w_rs[k])) w_prs[k] = w_prd[j];
        if (w_alloc[j] && (w_rd[j] == w_rt[k])) w_prt[k] = w_prd[j];
        if (w_alloc[j] && (w_rd[j] == w_rd[k])) w_old[k] = w_prd[j];
      end
      if (!w_alloc[k]) w_old[k] = '0;

      w_alloc_cnt = w_alloc_cnt + CNT_W'(w_alloc[k]);

      ren_prs[k*PHYS_REG_WIDTH +: PHYS_REG_WIDTH]     = w_prs[k];
      ren_prt[k*PHYS_REG_WIDTH +: PHYS_REG_WIDTH]     = w_prt[k];
      ren_prd[k*PHYS_REG_WIDTH +: PHYS_REG_WIDTH]     = w_prd[k];
      ren_old_prd[k*PHYS_REG_WIDTH +: PHYS_REG_WIDTH] = w_old[k];
    end
  end

  // Readiness uses the registered count only, so a register returned by a
  // commit this cycle cannot be handed out until the next cycle.
  assign ren_ready  = !flush && (r_free_count >= (PHYS_REG_WIDTH+1)'(w_alloc_cnt));
  assign w_accept   = ren_ready && (|ren_valid);
  assign free_count = r_free_count;

  // A flush rewinds head to the committed head, including a commit that
  // retires in the same cycle; renames presented during a flush are dropped.
  always_comb begin
    w_tail_nxt  = commit_valid ? ptr_add(r_tail, CNT_W'(1)) : r_tail;
    w_chead_nxt = commit_valid ? ptr_add(r_commit_head, CNT_W'(1)) : r_commit_head;
    if (flush)         w_head_nxt = w_chead_nxt;
    else if (w_accept) w_head_nxt = ptr_add(r_head, w_alloc_cnt);
    else               w_head_nxt = r_head;
  end

  // Pointers and count. Reset places tail one full lap ahead of head so the
  // list starts full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head        <= '0;
      r_commit_head <= '0;
      r_tail        <= {1'b1, {IDX_W{1'b0}}};
      r_free_count  <= (PHYS_REG_WIDTH+1)'(FL_DEPTH);
    end else begin
      r_head        <= w_head_nxt;
      r_commit_head <= w_chead_nxt;
      r_tail        <= w_tail_nxt;
      r_free_count  <= ptr_diff(w_tail_nxt, w_head_nxt);
    end
  end

  // Rename maps. Within an accepted group a later slot's write to the same rd
  // lands last, leaving the youngest mapping in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_spec_map[i]   <= PHYS_REG_WIDTH'(i);
        r_commit_map[i] <= PHYS_REG_WIDTH'(i);
      end
    end else begin
      if (commit_valid) r_commit_map[commit_ard] <= commit_prd;
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          r_spec_map[i] <= (commit_valid && (commit_ard == ARCH_REG_WIDTH'(i)))
                           ? commit_prd : r_commit_map[i];
        end
      end else if (w_accept) begin
        for (int k = 0; k < RENAME_WIDTH; k++) begin
          if (w_alloc[k]) r_spec_map[w_rd[k]] <= w_prd[k];
        end
      end
    end
  end

  // Free-list storage: initially holds ARCH_REGS..PHYS_REGS-1 in order;
  // each commit appends the superseded register at tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < FL_DEPTH; j++) begin
        r_free_list[j] <= PHYS_REG_WIDTH'(ARCH_REGS + j);
      end
    end else if (commit_valid) begin
      r_free_list[r_tail[IDX_W-1:0]] <= commit_old_prd;
    end
  end

  // Retiring into a full free list, or retiring r0, indicates a broken
  // upstream reorder buffer.
  always_ff @(posedge clk) begin
    if (!rst && commit_valid) begin
      assert (r_free_count != (PHYS_REG_WIDTH+1)'(FL_DEPTH));
      assert (commit_ard != '0);
    end
  end

endmodule

// File: tb/tb_rename_unit_mw.sv
module tb_rename_unit_mw;
  localparam int AW  = 5;
  localparam int PW  = 6;
  localparam int RW  = 2;
  localparam int NA  = 32;
  localparam int FLD = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [RW-1:0]    ren_valid, ren_wen;
  logic [RW*AW-1:0] ren_rs, ren_rt, ren_rd;
  logic             ren_ready;
  logic [RW*PW-1:0] ren_prs, ren_prt, ren_prd, ren_old_prd;
  logic             commit_valid;
  logic [AW-1:0]    commit_ard;
  logic [PW-1:0]    commit_prd, commit_old_prd;
  logic             flush;
  logic [PW:0]      free_count;

  always #5 clk = ~clk;

  rename_unit_mw #(.ARCH_REG_WIDTH(AW), .PHYS_REG_WIDTH(PW), .RENAME_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .ren_valid(ren_valid), .ren_wen(ren_wen),
    .ren_rs(ren_rs), .ren_rt(ren_rt), .ren_rd(ren_rd),
    .ren_ready(ren_ready),
    .ren_prs(ren_prs), .ren_prt(ren_prt), .ren_prd(ren_prd), .ren_old_prd(ren_old_prd),
    .commit_valid(commit_valid), .commit_ard(commit_ard),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .flush(flush), .free_count(free_count)
  );

  typedef struct packed {
    logic               grp;
    logic               rdy;
    logic [1:0]         vm;
    logic [1:0][PW-1:0] prs;
    logic [1:0][PW-1:0] prt;
    logic [1:0][PW-1:0] prd;
    logic [1:0][PW-1:0] old;
    logic [PW:0]        fc;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] ard;
    logic [PW-1:0] prd;
    logic [PW-1:0] old;
  } rob_t;

  // Reference model: architectural maps, free registers as an ordered queue,
  // and the in-flight (renamed, not yet retired) writers in program order.
  int   spec_m   [NA];
  int   commit_m [NA];
  int   freeq [$];
  rob_t rob [$];
  exp_t sb [$];

  int total = 0;
  int bad   = 0;

  function automatic void check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      spec_m[i]   = i;
      commit_m[i] = i;
    end
    freeq.delete();
    for (int j = 0; j < FLD; j++) freeq.push_back(NA + j);
    rob.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ren_valid = '0; ren_wen = '0; ren_rs = '0; ren_rt = '0; ren_rd = '0;
    commit_valid = 1'b0; commit_ard = '0; commit_prd = '0; commit_old_prd = '0;
    flush = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of stimulus, predict the response, and return at the
  // following negedge. A commit is only issued if the model has an in-flight
  // writer, which keeps every retirement legal.
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input int rs0, input int rt0, input int rd0,
                      input int rs1, input int rt1, input int rd1,
                      input bit cmt, input bit fl);
    exp_t e;
    rob_t c, r;
    int   tmap [NA];
    int   rs [2];
    int   rt [2];
    int   rd [2];
    bit   al [2];
    int   nal, n;
    bit   did_c;
    @(posedge clk); #1;
    rs[0] = rs0; rt[0] = rt0; rd[0] = rd0;
    rs[1] = rs1; rt[1] = rt1; rd[1] = rd1;
    did_c = cmt && (rob.size() > 0);
    c = '0;
    if (did_c) c = rob.pop_front();

    ren_valid = v;
    ren_wen   = w;
    ren_rs    = {AW'(rs1), AW'(rs0)};
    ren_rt    = {AW'(rt1), AW'(rt0)};
    ren_rd    = {AW'(rd1), AW'(rd0)};
    commit_valid   = did_c;
    commit_ard     = c.ard;
    commit_prd     = c.prd;
    commit_old_prd = c.old;
    flush          = fl;

    nal = 0;
    for (int k = 0; k < 2; k++) begin
      al[k] = v[k] && w[k] && (rd[k] != 0);
      if (al[k]) nal++;
    end
    e     = '0;
    e.grp = |v;
    e.vm  = v;
    e.fc  = (PW+1)'(freeq.size());
    e.rdy = !fl && (freeq.size() >= nal);

    // Sequential meaning of the group: each slot sees the maps as left by
    // the older slot.
    tmap = spec_m;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      e.prs[k] = (rs[k] == 0) ? '0 : PW'(tmap[rs[k]]);
      e.prt[k] = (rt[k] == 0) ? '0 : PW'(tmap[rt[k]]);
      if (al[k] && n < freeq.size()) begin
        e.prd[k]     = PW'(freeq[n]);
        e.old[k]     = PW'(tmap[rd[k]]);
        tmap[rd[k]]  = freeq[n];
        n++;
      end
    end
    sb.push_back(e);

    if (e.grp && e.rdy) begin
      for (int k = 0; k < 2; k++) begin
        if (al[k]) begin
          r.ard = AW'(rd[k]);
          r.prd = e.prd[k];
          r.old = e.old[k];
          rob.push_back(r);
          void'(freeq.pop_front());
        end
      end
      spec_m = tmap;
    end
    if (did_c) commit_m[c.ard] = c.prd;
    if (fl) begin
      spec_m = commit_m;
      for (int i = rob.size() - 1; i >= 0; i--) freeq.push_front(rob[i].prd);
      rob.delete();
    end
    if (did_c) freeq.push_back(c.old);
    @(negedge clk);
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: free_count and ready every cycle, rename results for every
  // valid slot of an accepted group.
  exp_t m_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      check("free_count", int'(free_count), int'(m_e.fc));
      check("ren_ready", int'(ren_ready), int'(m_e.rdy));
      if (m_e.grp && m_e.rdy) begin
        for (int k = 0; k < 2; k++) begin
          if (m_e.vm[k]) begin
            check($sformatf("prs%0d", k), int'(ren_prs[k*PW +: PW]), int'(m_e.prs[k]));
            check($sformatf("prt%0d", k), int'(ren_prt[k*PW +: PW]), int'(m_e.prt[k]));
            check($sformatf("prd%0d", k), int'(ren_prd[k*PW +: PW]), int'(m_e.prd[k]));
            check($sformatf("old_prd%0d", k), int'(ren_old_prd[k*PW +: PW]), int'(m_e.old[k]));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ph, cm, fl;
    logic [1:0] v, w;
    rst = 1'b0;

    // Reset state
    do_reset();
    idle();
    check("rst_free_count", int'(free_count), 32);
    check("rst_ready", int'(ren_ready), 1);

    // Single allocation then dependent read
    step(2'b01, 2'b01, 0, 0, 5, 0, 0, 0, 1'b0, 1'b0);
    check("d1_prd0", int'(ren_prd[PW-1:0]), 32);
    check("d1_old0", int'(ren_old_prd[PW-1:0]), 5);
    step(2'b01, 2'b00, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    check("d1_prs0", int'(ren_prs[PW-1:0]), 32);
    check("d1_fc", int'(free_count), 31);

    // Intra-group bypass with both slots writing r3
    do_reset();
    step(2'b11, 2'b11, 0, 0, 3, 3, 0, 3, 1'b0, 1'b0);
    check("d2_prd0", int'(ren_prd[PW-1:0]), 32);
    check("d2_prs1", int'(ren_prs[2*PW-1:PW]), 32);
    check("d2_prd1", int'(ren_prd[2*PW-1:PW]), 33);
    check("d2_old1", int'(ren_old_prd[2*PW-1:PW]), 32);
    step(2'b01, 2'b00, 3, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    check("d2_map3", int'(ren_prs[PW-1:0]), 33);

    // Exhaust free list, then one commit
    do_reset();
    for (int i = 0; i < 16; i++)
      step(2'b11, 2'b11, 0, 0, ((2*i) % 31) + 1, 0, 0, ((2*i + 1) % 31) + 1, 1'b0, 1'b0);
    step(2'b01, 2'b01, 0, 0, 7, 0, 0, 0, 1'b0, 1'b0);
    check("d3_fc_empty", int'(free_count), 0);
    check("d3_ready_alloc", int'(ren_ready), 0);
    step(2'b11, 2'b00, 1, 2, 0, 3, 4, 0, 1'b0, 1'b0);
    check("d3_ready_nowrite", int'(ren_ready), 1);
    step(2'b01, 2'b01, 0, 0, 7, 0, 0, 0, 1'b1, 1'b0);
    check("d3_ready_commit_cycle", int'(ren_ready), 0);
    step(2'b01, 2'b01, 0, 0, 7, 0, 0, 0, 1'b0, 1'b0);
    check("d3_ready_after", int'(ren_ready), 1);
    check("d3_prd_freed", int'(ren_prd[PW-1:0]), 1);

    // Flush discards three renames
    do_reset();
    step(2'b11, 2'b11, 0, 0, 1, 0, 0, 2, 1'b0, 1'b0);
    step(2'b01, 2'b01, 0, 0, 3, 0, 0, 0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    step(2'b11, 2'b01, 1, 2, 4, 3, 0, 0, 1'b0, 1'b0);
    check("d4_r1", int'(ren_prs[PW-1:0]), 1);
    check("d4_r2", int'(ren_prt[PW-1:0]), 2);
    check("d4_r3", int'(ren_prs[2*PW-1:PW]), 3);
    check("d4_fc", int'(free_count), 32);
    check("d4_prd", int'(ren_prd[PW-1:0]), 32);

    // Commit in the flush cycle
    do_reset();
    step(2'b01, 2'b01, 0, 0, 1, 0, 0, 0, 1'b0, 1'b0);
    step(2'b01, 2'b01, 0, 0, 2, 0, 0, 0, 1'b0, 1'b0);
    step(2'b01, 2'b01, 0, 0, 3, 0, 0, 0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    step(2'b01, 2'b01, 1, 2, 5, 0, 0, 0, 1'b0, 1'b0);
    check("d5_r1", int'(ren_prs[PW-1:0]), 32);
    check("d5_r2", int'(ren_prt[PW-1:0]), 2);
    check("d5_fc", int'(free_count), 32);
    check("d5_prd", int'(ren_prd[PW-1:0]), 33);

    // r0 destination and source
    do_reset();
    step(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    check("d6_prd", int'(ren_prd[PW-1:0]), 0);
    check("d6_prs", int'(ren_prs[PW-1:0]), 0);
    check("d6_old", int'(ren_old_prd[PW-1:0]), 0);
    idle();
    check("d6_fc", int'(free_count), 32);

    // Randomized traffic in phases: balanced, fill-up (rare commits, no
    // flush), and drain (frequent commits).
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ph = (n / 200) % 3;
      v  = 2'($urandom_range(0, 3));
      w  = 2'($urandom_range(0, 3));
      cm = (ph == 0) ? ($urandom_range(0, 2) == 0) :
           (ph == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      fl = (ph == 1) ? 0 : ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0)
        step(v, w, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             cm[0], fl[0]);
      else
        step(v, w, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             cm[0], fl[0]);
    end
    idle();
    idle();
    @(posedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
